// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle MIPS-subset control FSM.
// Sequences fetch/decode/execute/memory/writeback, drives the datapath
// control lines, latches rs/rt during DECODE and decodes the ALU control.
module mc_control_unit #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instruction,
  input  logic              mem_ready,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              IRWrite,
  output logic              ALUSrcA,
  output logic              RegWrite,
  output logic              RegDst,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic [1:0]        PCSource,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ALUOp,
  output logic [2:0]        alu_ctrl,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  output logic              illegal,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     cur, nxt;
  logic       live;      // low until the first edge after reset release
  logic       ready;
  logic       bad;
  logic       funct_ok;
  logic [5:0] opcode, funct;
  logic       unused_bits;

  assign ready       = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign opcode      = instruction[DATA_W-1 -: 6];
  assign funct       = instruction[5:0];
  assign state       = cur;
  assign unused_bits = ^instruction;

  // Supported R-type function codes.
  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  // Next-state logic; bad flags an unsupported opcode/funct on the way back to FETCH.
  always_comb begin
    nxt = cur;
    bad = 1'b0;
    case (cur)
      S_FETCH:   if (live && ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADDR;
          OP_RTYPE:     nxt = S_REXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_IEXEC;
          default: begin
            nxt = S_FETCH;
            bad = 1'b1;
          end
        endcase
      end
      S_MEMADDR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (ready) nxt = S_MEMWB;
      S_MEMWR:   if (ready) nxt = S_FETCH;
      S_REXEC: begin
        nxt = funct_ok ? S_RWB : S_FETCH;
        bad = !funct_ok;
      end
      S_IEXEC:   nxt = S_IWB;
      default:   nxt = S_FETCH;
    endcase
  end

  // State register, register-address latches and the illegal pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_FETCH;
      live    <= 1'b0;
      rs_addr <= '0;
      rt_addr <= '0;
      illegal <= 1'b0;
    end else begin
      live    <= 1'b1;
      cur     <= nxt;
      illegal <= bad;
      if (cur == S_DECODE) begin
        rs_addr <= instruction[21 +: REG_AW];
        rt_addr <= instruction[16 +: REG_AW];
      end
    end
  end

  // Moore decode of the state register; only IRWrite/PCWrite in FETCH look at mem_ready.
  always_comb begin
    IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; IRWrite = 1'b0;
    ALUSrcA = 1'b0; RegWrite = 1'b0; RegDst = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0;
    PCSource = 2'b00; ALUSrcB = 2'b00; ALUOp = 2'b00;
    if (live) begin
      case (cur)
        S_FETCH: begin
          MemRead = 1'b1; ALUSrcB = 2'b01;
          IRWrite = ready; PCWrite = ready;
        end
        S_DECODE:  ALUSrcB = 2'b11;
        S_MEMADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        S_MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
        S_MEMWB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        S_MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
        S_REXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        S_RWB:     begin RegWrite = 1'b1; RegDst = 1'b1; end
        S_BRANCH: begin
          ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01;
        end
        S_JUMP:    begin PCWrite = 1'b1; PCSource = 2'b10; end
        S_IEXEC:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        S_IWB:     RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  // ALU control from ALUOp and funct; unknown funct falls back to add.
  always_comb begin
    alu_ctrl = 3'b000;
    if (live) begin
      case (ALUOp)
        2'b01: alu_ctrl = 3'b110;
        2'b10: begin
          case (funct)
            6'b100010: alu_ctrl = 3'b110;
            6'b100100: alu_ctrl = 3'b000;
            6'b100101: alu_ctrl = 3'b001;
            6'b101010: alu_ctrl = 3'b111;
            default:   alu_ctrl = 3'b010;
          endcase
        end
        default: alu_ctrl = 3'b010;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed reset checks, then a randomized instruction
// stream with random memory stalls scored against an instruction-level model.
module tb_mc_control_unit;
  localparam int NPROG = 128;
  localparam int NRDY  = 6000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic        PCWrite, PCWriteCond, illegal;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [2:0]  alu_ctrl;
  logic [4:0]  rs_addr, rt_addr;
  logic [3:0]  state;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .alu_ctrl(alu_ctrl), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .illegal(illegal), .state(state)
  );

  typedef struct {
    logic [31:0] ins;
    logic [63:0] path;   // visited states, one nibble each, oldest first
    int          cyc;
    logic        ill;
    int          rw;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ndone = 0;
  exp_t        sbq[$];
  logic [31:0] prog[$];
  bit          rdy[NRDY];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [18:0] ctl_vec();
    return {IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst,
            PCWrite, PCWriteCond, PCSource, ALUSrcB, ALUOp, alu_ctrl};
  endfunction

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  function automatic logic [2:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Control table per state as listed for each state; unlisted lines are 0.
  function automatic logic [18:0] ctl_exp(input logic [3:0] st, input logic r,
                                          input logic [5:0] fn);
    logic iord, mrd, mwr, m2r, irw, srca, rgw, rdst, pcw, pcwc;
    logic [1:0] pcs, srcb, aop;
    logic [2:0] ac;
    {iord, mrd, mwr, m2r, irw, srca, rgw, rdst, pcw, pcwc} = '0;
    pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; srcb = 2'b01; irw = r; pcw = r; end
      4'd1:  srcb = 2'b11;
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rgw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin srca = 1; aop = 2'b10; end
      4'd7:  begin rgw = 1; rdst = 1; end
      4'd8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; end
      4'd11: rgw = 1;
      default: return '1;
    endcase
    ac = (aop == 2'b01) ? 3'b110 : (aop == 2'b10) ? fn_alu(fn) : 3'b010;
    return {iord, mrd, mwr, m2r, irw, srca, rgw, rdst, pcw, pcwc, pcs, srcb, aop, ac};
  endfunction

  function automatic bit rdy_at(input int t);
    return (t < NRDY) ? rdy[t] : 1'b1;
  endfunction

  // Instruction-level model: walks the phases of one instruction starting at
  // cycle t, stretching each memory phase by the ready-low cycles it meets.
  task automatic model(input logic [31:0] ins, inout int t, output exp_t e);
    int t0;
    logic [5:0] op;
    t0 = t; op = ins[31:26];
    e.ins = ins; e.ill = 1'b0; e.rw = 0;
    while (!rdy_at(t)) t++;
    t++;
    t++;
    e.path = 64'h01;
    case (op)
      6'h23: begin
        t++; while (!rdy_at(t)) t++; t += 2;
        e.path = 64'h01234; e.rw = 1;
      end
      6'h2B: begin
        t++; while (!rdy_at(t)) t++; t++;
        e.path = 64'h0125;
      end
      6'h00: begin
        t++;
        if (funct_legal(ins[5:0])) begin t++; e.path = 64'h0167; e.rw = 1; end
        else begin e.path = 64'h016; e.ill = 1'b1; end
      end
      6'h04: begin t++; e.path = 64'h018; end
      6'h02: begin t++; e.path = 64'h019; end
      6'h08: begin t += 2; e.path = 64'h01AB; e.rw = 1; end
      default: e.ill = 1'b1;
    endcase
    e.cyc = t - t0;
  endtask

  // Acts as IR and memory: loads the next instruction after each IRWrite cycle.
  task automatic drive();
    int pidx = 0, mt = 0, dc = 1;
    bit fire;
    exp_t e;
    @(posedge clk); #1;
    mem_ready = rdy[0];
    forever begin
      @(negedge clk);
      fire = IRWrite;
      @(posedge clk); #1;
      if (fire && pidx < NPROG) begin
        instruction = prog[pidx];
        model(prog[pidx], mt, e);
        sbq.push_back(e);
        pidx++;
      end
      mem_ready = rdy_at(dc);
      dc++;
    end
  endtask

  // Checks controls every cycle; scores an instruction when FETCH is re-entered.
  task automatic monitor();
    int mc = 0, cnt = 0, rw = 0;
    logic [3:0] st, pst = 4'd0;
    logic [63:0] path = '0;
    bit entry;
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      st = state;
      chk($sformatf("ctl st%0d cyc%0d", st, mc), 64'(ctl_vec()),
          64'(ctl_exp(st, mem_ready, instruction[5:0])));
      entry = (mc > 0) && (st == 4'd0) && (pst != 4'd0);
      if (entry) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_empty: instruction retired with none issued at cyc%0d", mc);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("path %08h", e.ins), path, e.path);
          chk($sformatf("cycles %08h", e.ins), 64'(cnt), 64'(e.cyc));
          chk($sformatf("illegal %08h", e.ins), 64'(illegal), 64'(e.ill));
          chk($sformatf("regwrites %08h", e.ins), 64'(rw), 64'(e.rw));
          chk($sformatf("rs_addr %08h", e.ins), 64'(rs_addr), 64'(e.ins[25:21]));
          chk($sformatf("rt_addr %08h", e.ins), 64'(rt_addr), 64'(e.ins[20:16]));
          ndone++;
        end
      end else begin
        chk($sformatf("illegal_idle cyc%0d", mc), 64'(illegal), 64'h0);
      end
      if (mc == 0 || entry) begin
        path = 64'(st); cnt = 1; rw = int'(RegWrite);
      end else begin
        if (st != pst) path = (path << 4) | 64'(st);
        cnt++;
        rw += int'(RegWrite);
      end
      pst = st;
      mc++;
      if (ndone == NPROG) break;
    end
  endtask

  initial begin
    bit found;
    logic [5:0] op;
    logic [5:0] legal_fn[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] ops[6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};

    // Directed instructions first, then a random mix including illegal codes.
    prog = '{32'h8C220004, 32'h00221822, 32'h10220003, 32'h08000010,
             32'hFC000000, 32'h0000003F, 32'hAC430008, 32'h2025FFFF};
    while (prog.size() < NPROG) begin
      case ($urandom_range(0, 7))
        0: op = 6'h23;
        1: op = 6'h2B;
        2, 3: op = 6'h00;
        4: op = 6'h04;
        5: op = 6'h02;
        6: op = 6'h08;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (op inside {ops}) op = 6'h3F;
        end
      endcase
      if (op == 6'h00)
        prog.push_back({op, 20'($urandom), ($urandom_range(0, 3) == 0) ?
                        6'($urandom_range(0, 63)) : legal_fn[$urandom_range(0, 4)]});
      else
        prog.push_back({op, 26'($urandom)});
    end
    for (int i = 0; i < NRDY; i++) rdy[i] = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < 40; i++) rdy[i] = (i >= 3);

    // Reset, first FETCH, and an abort in the middle of a load.
    rst_n = 1'b0; mem_ready = 1'b1; instruction = 32'h8C220004;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'(state), 64'h0);
    chk("reset_ctl", 64'(ctl_vec()), 64'h0);
    chk("reset_illegal", 64'(illegal), 64'h0);
    rst_n = 1'b1;
    #1 chk("release_no_fetch_yet", 64'(MemRead), 64'h0);
    @(posedge clk); #1;
    chk("fetch_memread", 64'(MemRead), 64'h1);
    chk("fetch_irwrite", 64'(IRWrite), 64'h1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (state == 4'd3) begin found = 1'b1; break; end
    end
    chk("reach_memrd", 64'(found), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_state", 64'(state), 64'h0);
    chk("abort_ctl", 64'(ctl_vec()), 64'h0);
    chk("abort_rs_rt", 64'({rs_addr, rt_addr}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("refetch_memread", 64'(MemRead), 64'h1);
    chk("refetch_state", 64'(state), 64'h0);

    // Scoreboarded random run from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0; instruction = '0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fork
      drive();
      monitor();
      begin
        repeat (5000) @(posedge clk);
        n_chk++; n_fail++;
        $display("FAIL timeout: %0d of %0d instructions retired", ndone, NPROG);
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
